// File: rtl/sto_peak_search_if.sv
`default_nettype none
// ============================================================================
// Module   : sto_peak_search_if
// Summary  : Control, metric-stream and estimate bundle for sto_peak_search.
// Revision : 1.0  initial release
// ============================================================================
interface sto_peak_search_if #(
   parameter int LEN_W = 12,
   parameter int IDX_W = 13,
   parameter int MET_W = 16
);
   logic             start;
   logic [LEN_W-1:0] nfft;
   logic [LEN_W-1:0] ng;
   logic [LEN_W-1:0] com_delay;
   logic             met_valid;
   logic [MET_W-1:0] met;

   logic             busy;
   logic             est_valid;
   logic [LEN_W-1:0] est_sto;
   logic [IDX_W-1:0] peak_idx;
   logic [MET_W-1:0] peak_met;
   logic             err;

   modport master (
      output start, nfft, ng, com_delay, met_valid, met,
      input  busy, est_valid, est_sto, peak_idx, peak_met, err
   );

   modport slave (
      input  start, nfft, ng, com_delay, met_valid, met,
      output busy, est_valid, est_sto, peak_idx, peak_met, err
   );
endinterface
`default_nettype wire

// File: rtl/sto_peak_search.sv
`default_nettype none
// ============================================================================
// Module   : sto_peak_search
// Summary  : Searches one Nfft+Ng window of CP metrics for its peak and emits
//            est_sto = W - com_delay - peak_idx, clamped with a range flag.
//            Define STO_AVG_EN to average 2^AVG_LOG2 windows per estimate.
// Revision : 1.0  initial release
// ============================================================================
module sto_peak_search #(
   parameter int LEN_W    = 12,
   parameter int IDX_W    = 13,
   parameter int MET_W    = 16,
   parameter int AVG_LOG2 = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   sto_peak_search_if.slave bus
);

   localparam int c_W_W = LEN_W + 1;
   localparam int c_D_W = LEN_W + IDX_W;
   localparam logic signed [c_D_W-1:0] c_EST_MAX = c_D_W'((64'd1 << LEN_W) - 64'd1);

   localparam logic [1:0] c_IDLE   = 2'd0;
   localparam logic [1:0] c_SEARCH = 2'd1;
   localparam logic [1:0] c_CALC   = 2'd2;

   if (AVG_LOG2 < 1 || AVG_LOG2 > 8) begin : g_avg_log2_check
      $error("sto_peak_search: AVG_LOG2 must be in 1..8");
   end

   logic [1:0]       state_q,     state_d;
   logic [c_W_W-1:0] win_len_q,   win_len_d;
   logic [LEN_W-1:0] com_delay_q, com_delay_d;
   logic [IDX_W-1:0] cnt_q,       cnt_d;
   logic [IDX_W-1:0] max_idx_q,   max_idx_d;
   logic [MET_W-1:0] max_met_q,   max_met_d;

   logic             est_valid_q, est_valid_d;
   logic [LEN_W-1:0] est_sto_q,   est_sto_d;
   logic [IDX_W-1:0] peak_idx_q,  peak_idx_d;
   logic [MET_W-1:0] peak_met_q,  peak_met_d;
   logic             err_q,       err_d;

   logic [c_W_W-1:0]        w_start_len;
   logic [c_W_W-1:0]        w_last;
   logic signed [c_D_W-1:0] w_d;

   assign w_start_len = c_W_W'(bus.nfft) + c_W_W'(bus.ng);
   assign w_last      = win_len_q - c_W_W'(1);

   // Zero-extended operands, so the subtraction lands as a signed distance
   assign w_d = c_D_W'(win_len_q) - c_D_W'(com_delay_q) - c_D_W'(max_idx_q);

`ifdef STO_AVG_EN
   localparam int c_A_W = c_D_W + AVG_LOG2;
   localparam logic [AVG_LOG2-1:0] c_LAST_WIN = {AVG_LOG2{1'b1}};

   logic signed [c_A_W-1:0] acc_q, acc_d;
   logic [AVG_LOG2-1:0]     win_cnt_q, win_cnt_d;
   logic signed [c_A_W-1:0] w_acc_sum;
   logic signed [c_D_W-1:0] w_acc_avg;

   assign w_acc_sum = acc_q + c_A_W'(w_d);
   assign w_acc_avg = c_D_W'(w_acc_sum >>> AVG_LOG2);
`endif

   // Returns {err, est_sto}
   function automatic logic [LEN_W:0] f_clamp(input logic signed [c_D_W-1:0] v);
      if (v[c_D_W-1]) begin
         return {1'b1, {LEN_W{1'b0}}};
      end else if (v > c_EST_MAX) begin
         return {1'b1, {LEN_W{1'b1}}};
      end else begin
         return {1'b0, v[LEN_W-1:0]};
      end
   endfunction

   always_comb begin
      state_d     = state_q;
      win_len_d   = win_len_q;
      com_delay_d = com_delay_q;
      cnt_d       = cnt_q;
      max_idx_d   = max_idx_q;
      max_met_d   = max_met_q;
      est_valid_d = 1'b0;
      est_sto_d   = est_sto_q;
      peak_idx_d  = peak_idx_q;
      peak_met_d  = peak_met_q;
      err_d       = err_q;
`ifdef STO_AVG_EN
      acc_d       = acc_q;
      win_cnt_d   = win_cnt_q;
`endif

      // start wins over everything, including a coincident final sample
      if (bus.start) begin
         win_len_d   = w_start_len;
         com_delay_d = bus.com_delay;
         cnt_d       = '0;
         max_idx_d   = '0;
         max_met_d   = '0;
         state_d     = (w_start_len == '0) ? c_CALC : c_SEARCH;
`ifdef STO_AVG_EN
         acc_d       = '0;
         win_cnt_d   = '0;
`endif
      end else begin
         case (state_q)
            c_SEARCH: begin
               if (bus.met_valid) begin
                  if (cnt_q == '0 || bus.met > max_met_q) begin
                     max_met_d = bus.met;
                     max_idx_d = cnt_q;
                  end
                  if (c_W_W'(cnt_q) == w_last) begin
                     state_d = c_CALC;
                  end else begin
                     cnt_d = cnt_q + IDX_W'(1);
                  end
               end
            end

            c_CALC: begin
`ifdef STO_AVG_EN
               if (win_cnt_q == c_LAST_WIN) begin
                  {err_d, est_sto_d} = f_clamp(w_acc_avg);
                  peak_idx_d  = max_idx_q;
                  peak_met_d  = max_met_q;
                  est_valid_d = 1'b1;
                  acc_d       = '0;
                  win_cnt_d   = '0;
                  state_d     = c_IDLE;
               end else begin
                  acc_d     = w_acc_sum;
                  win_cnt_d = win_cnt_q + 1'b1;
                  cnt_d     = '0;
                  max_idx_d = '0;
                  max_met_d = '0;
                  state_d   = (win_len_q == '0) ? c_CALC : c_SEARCH;
               end
`else
               {err_d, est_sto_d} = f_clamp(w_d);
               peak_idx_d  = max_idx_q;
               peak_met_d  = max_met_q;
               est_valid_d = 1'b1;
               state_d     = c_IDLE;
`endif
            end

            c_IDLE:  state_d = c_IDLE;
            default: state_d = c_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= c_IDLE;
         win_len_q   <= '0;
         com_delay_q <= '0;
         cnt_q       <= '0;
         max_idx_q   <= '0;
         max_met_q   <= '0;
         est_valid_q <= 1'b0;
         est_sto_q   <= '0;
         peak_idx_q  <= '0;
         peak_met_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         win_len_q   <= win_len_d;
         com_delay_q <= com_delay_d;
         cnt_q       <= cnt_d;
         max_idx_q   <= max_idx_d;
         max_met_q   <= max_met_d;
         est_valid_q <= est_valid_d;
         est_sto_q   <= est_sto_d;
         peak_idx_q  <= peak_idx_d;
         peak_met_q  <= peak_met_d;
         err_q       <= err_d;
      end
   end

`ifdef STO_AVG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q     <= '0;
         win_cnt_q <= '0;
      end else begin
         acc_q     <= acc_d;
         win_cnt_q <= win_cnt_d;
      end
   end
`endif

   assign bus.busy      = (state_q != c_IDLE);
   assign bus.est_valid = est_valid_q;
   assign bus.est_sto   = est_sto_q;
   assign bus.peak_idx  = peak_idx_q;
   assign bus.peak_met  = peak_met_q;
   assign bus.err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sto_peak_search.sv
`default_nettype none
// ============================================================================
// Module   : tb_sto_peak_search
// Summary  : Directed bench with a window-level reference model for sto_peak_search.
// Revision : 1.0  initial release
// ============================================================================
module tb_sto_peak_search;
   localparam int LEN_W    = 12;
   localparam int IDX_W    = 13;
   localparam int MET_W    = 16;
   localparam int AVG_LOG2 = 2;
`ifdef STO_AVG_EN
   localparam int N_WIN = 1 << AVG_LOG2;
`else
   localparam int N_WIN = 1;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sto_peak_search_if #(.LEN_W(LEN_W), .IDX_W(IDX_W), .MET_W(MET_W)) bus();

   sto_peak_search #(.LEN_W(LEN_W), .IDX_W(IDX_W), .MET_W(MET_W), .AVG_LOG2(AVG_LOG2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model (window level) ----------------
   typedef struct {
      int cyc;
      int sto;
      int idx;
      int met;
      int err;
   } exp_t;

   exp_t   exp_q[$];
   int     m_samples[$];
   int     m_w, m_cd, m_restart_edge, m_win_done;
   bit     m_active;
   longint m_sum;
   int     h_sto, h_idx, h_met, h_err;
   int     n_ev, last_ev_cyc, last_drive_cyc;

   task automatic m_window_done(input int edge_e, input int idx, input int met);
      longint d, q;
      exp_t   e;
      d = longint'(m_w) - longint'(m_cd) - longint'(idx);
      m_sum += d;
      m_win_done++;
      if (m_win_done == N_WIN) begin
         q = m_sum / N_WIN;
         if (m_sum < 0 && (m_sum % N_WIN) != 0) q = q - 1;
         e.cyc = edge_e + 1;
         e.idx = idx;
         e.met = met;
         if (q < 0) begin
            e.sto = 0; e.err = 1;
         end else if (q > (1 << LEN_W) - 1) begin
            e.sto = (1 << LEN_W) - 1; e.err = 1;
         end else begin
            e.sto = int'(q); e.err = 0;
         end
         exp_q.push_back(e);
         m_active   = 1'b0;
         m_sum      = 0;
         m_win_done = 0;
      end else begin
         m_samples.delete();
         m_restart_edge = edge_e + 1;
      end
   endtask

   task automatic m_step(input bit st, input int nfft, input int ng, input int cd,
                         input bit v, input int met);
      int edge_n, mx, ix;
      edge_n = cyc + 1;
      if (st) begin
         if (exp_q.size() > 0 && exp_q[$].cyc == edge_n) exp_q.pop_back();
         m_w = nfft + ng;
         m_cd = cd;
         m_samples.delete();
         m_sum = 0;
         m_win_done = 0;
         m_restart_edge = -1;
         if (m_w == 0) begin
            for (int k = 0; k < N_WIN; k++) m_window_done(edge_n + k, 0, 0);
            m_active = 1'b0;
         end else begin
            m_active = 1'b1;
         end
      end else if (v && m_active && edge_n != m_restart_edge) begin
         m_samples.push_back(met);
         if (m_samples.size() == m_w) begin
            mx = m_samples[0];
            ix = 0;
            foreach (m_samples[j]) if (m_samples[j] > mx) begin mx = m_samples[j]; ix = j; end
            m_window_done(edge_n, ix, mx);
         end
      end
   endtask

   task automatic m_reset();
      exp_q.delete();
      m_samples.delete();
      m_active = 1'b0;
      m_sum = 0;
      m_win_done = 0;
      h_sto = 0; h_idx = 0; h_met = 0; h_err = 0;
   endtask

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      logic [63:0] act_h, exp_h;
      exp_t e;
      if (rst_n) begin
         if (bus.est_valid === 1'b1) begin
            n_ev++;
            last_ev_cyc = cyc;
            if (exp_q.size() == 0) begin
               check("est_valid_unexpected", 64'(bus.est_valid), 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("est_valid_cycle", 64'(cyc), 64'(e.cyc));
               h_sto = e.sto; h_idx = e.idx; h_met = e.met; h_err = e.err;
            end
         end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            check("est_valid_missing", 64'(bus.est_valid), 64'd1);
            void'(exp_q.pop_front());
         end
         act_h = {22'd0, bus.err, bus.est_sto, bus.peak_idx, bus.peak_met};
         exp_h = {22'd0, h_err[0], h_sto[LEN_W-1:0], h_idx[IDX_W-1:0], h_met[MET_W-1:0]};
         check("held_outputs", act_h, exp_h);
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input bit st, input int nfft, input int ng, input int cd,
                        input bit v, input int met);
      @(negedge clk);
      bus.start     = st;
      bus.nfft      = LEN_W'(nfft);
      bus.ng        = LEN_W'(ng);
      bus.com_delay = LEN_W'(cd);
      bus.met_valid = v;
      bus.met       = MET_W'(met);
      last_drive_cyc = cyc;
      m_step(st, nfft, ng, cd, v, met);
   endtask

   function automatic int metric(input int i, input int pk, input int pm, input int tie);
      if (i == pk || i == tie) return pm;
      return (i * 37) % 400;
   endfunction

   // start (carrying an ignored sample), then N_WIN windows; returns last-sample drive cycle
   task automatic run_windows(input int nfft, input int ng, input int cd, input int p0,
                              input int p1, input int pm, input int tie, input bit gaps,
                              output int last_cyc);
      int w;
      w = nfft + ng;
      drive(1'b1, nfft, ng, cd, 1'b1, 16'hFFFF);
      for (int k = 0; k < N_WIN; k++) begin
         for (int i = 0; i < w; i++) begin
            if (gaps)
               for (int g = 0; g < 3 && $urandom_range(0, 2) == 0; g++)
                  drive(1'b0, nfft, ng, cd, 1'b0, 16'hFFFF);
            drive(1'b0, nfft, ng, cd, 1'b1, metric(i, (k % 2 == 0) ? p0 : p1, pm, tie));
            last_cyc = last_drive_cyc;
         end
         drive(1'b0, nfft, ng, cd, 1'b1, 16'hFFFF);
      end
   endtask

   task automatic finish_wait();
      for (int n = 0; n < 40 && (bus.busy || exp_q.size() != 0); n++)
         drive(1'b0, 0, 0, 0, 1'b0, 0);
      check("drain_timeout", {62'd0, bus.busy, exp_q.size() != 0}, 64'd0);
   endtask

   task automatic check_est(input string tag, input int sto, input int idx,
                            input int met, input int err);
      check({tag, "_est_sto"},  64'(bus.est_sto),  64'(sto));
      check({tag, "_peak_idx"}, 64'(bus.peak_idx), 64'(idx));
      check({tag, "_peak_met"}, 64'(bus.peak_met), 64'(met));
      check({tag, "_err"},      64'(bus.err),      64'(err));
   endtask

   initial begin
      int l, s, ev0;
      m_reset();
      n_ev = 0;
      last_ev_cyc = -1;
      bus.start = 1'b0; bus.nfft = '0; bus.ng = '0; bus.com_delay = '0;
      bus.met_valid = 1'b0; bus.met = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_est_valid", 64'(bus.est_valid), 64'd0);
      check_est("rst", 0, 0, 0, 0);
      rst_n = 1'b1;

      // single peak
      run_windows(64, 16, 3, 20, 20, 900, -1, 1'b0, l);
      finish_wait();
      check_est("peak", 57, 20, 900, 0);
      check("peak_latency", 64'(last_ev_cyc), 64'(l + 2));
      check("peak_busy_low", 64'(bus.busy), 64'd0);

      // tie-break: earliest index wins
      run_windows(64, 16, 3, 5, 5, 500, 40, 1'b0, l);
      finish_wait();
      check_est("tie", 72, 5, 500, 0);

      // underflow
      run_windows(64, 16, 70, 15, 15, 900, -1, 1'b0, l);
      finish_wait();
      check_est("under", 0, 15, 900, 1);

      // empty window
      drive(1'b1, 0, 0, 3, 1'b0, 0);
      s = last_drive_cyc;
      finish_wait();
      check_est("w0", 0, 0, 0, 1);
      check("w0_latency", 64'(last_ev_cyc), 64'(s + 1 + N_WIN));

      // d == 0 exactly, with stalls
      run_windows(64, 16, 70, 10, 10, 900, -1, 1'b1, l);
      finish_wait();
      check_est("zero", 0, 10, 900, 0);

      // stalled stream matches contiguous result
      run_windows(64, 16, 3, 20, 20, 900, -1, 1'b1, l);
      finish_wait();
      check_est("stall", 57, 20, 900, 0);

      // upper boundary and overflow
      run_windows(2000, 2100, 0, 5, 5, 900, -1, 1'b0, l);
      finish_wait();
      check_est("max", 4095, 5, 900, 0);
      run_windows(2000, 2100, 0, 0, 0, 900, -1, 1'b0, l);
      finish_wait();
      check_est("over", 4095, 0, 900, 1);

      // abort mid-window
      ev0 = n_ev;
      drive(1'b1, 64, 16, 3, 1'b0, 0);
      for (int i = 0; i < 30; i++) drive(1'b0, 64, 16, 3, 1'b1, metric(i, 10, 950, -1));
      run_windows(64, 16, 3, 50, 50, 900, -1, 1'b0, l);
      finish_wait();
      check("abort_ev_count", 64'(n_ev - ev0), 64'd1);
      check_est("abort", 27, 50, 900, 0);

      // start coincident with the final sample discards the window
      ev0 = n_ev;
      drive(1'b1, 64, 16, 3, 1'b0, 0);
      for (int i = 0; i < 79; i++) drive(1'b0, 64, 16, 3, 1'b1, metric(i, 10, 950, -1));
      run_windows(64, 16, 3, 50, 50, 900, -1, 1'b0, l);
      finish_wait();
      check("coinc_ev_count", 64'(n_ev - ev0), 64'd1);
      check_est("coinc", 27, 50, 900, 0);

      // back-to-back windows, start on the est_valid cycle
      ev0 = n_ev;
      run_windows(64, 16, 3, 20, 20, 900, -1, 1'b0, l);
      run_windows(64, 16, 3, 30, 30, 800, -1, 1'b0, l);
      finish_wait();
      check("b2b_ev_count", 64'(n_ev - ev0), 64'd2);
      check_est("b2b", 47, 30, 800, 0);

      // asynchronous reset mid-search
      drive(1'b1, 64, 16, 3, 1'b0, 0);
      for (int i = 0; i < 40; i++) drive(1'b0, 64, 16, 3, 1'b1, metric(i, 20, 900, -1));
      check("mid_busy", 64'(bus.busy), 64'd1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      m_reset();
      #1;
      check("arst_busy", 64'(bus.busy), 64'd0);
      check("arst_est_valid", 64'(bus.est_valid), 64'd0);
      check_est("arst", 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      ev0 = n_ev;
      for (int i = 0; i < 100; i++) drive(1'b0, 64, 16, 3, 1'b1, metric(i, 20, 900, -1));
      check("arst_no_ev", 64'(n_ev - ev0), 64'd0);
      check("arst_idle", 64'(bus.busy), 64'd0);

      // alternating peak positions (averaged when enabled)
      ev0 = n_ev;
      run_windows(64, 16, 3, 20, 22, 900, -1, 1'b0, l);
      finish_wait();
      check("alt_ev_count", 64'(n_ev - ev0), 64'd1);
`ifdef STO_AVG_EN
      check_est("alt", 56, 22, 900, 0);
`else
      check_est("alt", 57, 20, 900, 0);
`endif

      check("pending_estimates", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sto_peak_search.md
# sto_peak_search

Parametrised sequential sample-timing-offset estimator for the OFDM receive chain. Consumes a stream of cyclic-prefix correlation metrics, searches one window of Nfft+Ng samples for the peak, then computes `est_sto = (Nfft+Ng) - com_delay - peak_idx`. The result is registered and held until the next estimate. It sits between the CP correlator and the timing-correction stage. It replaces combinational STO arithmetic with a self-contained search, underflow/overflow detection and optional multi-symbol averaging.

## Interface
- `LEN_W`, 12: width of `nfft`, `ng`, `com_delay`, `est_sto`.
- `IDX_W`, 13: width of the sample index and `peak_idx`.
- `MET_W`, 16: width of the unsigned correlation metric.
- `AVG_LOG2`, 2: log2 of the number of windows averaged. Used only with `STO_AVG_EN`.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle pulse. Latches `nfft`, `ng`, `com_delay` and begins a search.
- `nfft`, `ng`, `com_delay`  in  LEN_W each  configuration, sampled on `start`.
- `met_valid`  in  1  metric sample strobe.
- `met`  in  MET_W  unsigned correlation metric.
- `busy`  out  1  high while not IDLE.
- `est_valid`  out  1  one-cycle pulse when a new estimate is available.
- `est_sto`  out  LEN_W  estimate, held between pulses.
- `peak_idx`  out  IDX_W  index of the peak in the last window, held.
- `peak_met`  out  MET_W  metric value at that peak, held.
- `err`  out  1  range flag for the last estimate, held.

## Operation
- States: IDLE, SEARCH, CALC.
- IDLE → SEARCH on `start`:
  - latch `W = nfft + ng` (LEN_W+1 bits, no overflow) and `com_delay`;
  - clear the sample counter and the running max;
  - if W == 0, go directly to CALC with peak_idx = 0.
- SEARCH, per accepted sample (`met_valid` = 1) at counter value i:
  - if i == 0 or `met` > running max (strict), store max = `met` and idx = i;
  - ties keep the earliest index;
  - when i == W-1, go to CALC; otherwise increment i.
  - `met_valid` = 0 stalls the counter with no other effect.
- CALC:
  - compute `d = W - com_delay - idx` in signed LEN_W+IDX_W-wide arithmetic;
  - if d < 0: `est_sto` = 0, `err` = 1;
  - if d > 2^LEN_W-1: `est_sto` = all ones, `err` = 1;
  - otherwise `est_sto` = d, `err` = 0;
  - update `peak_idx`/`peak_met`, pulse `est_valid`, return to IDLE.
- `start` in SEARCH or CALC: abort the current window, relatch configuration, restart SEARCH. No `est_valid` is issued for the aborted window.
- `start` and the final sample in the same cycle: `start` wins and the window is discarded.
- Inputs outside SEARCH are ignored.

## Timing
- Reset values: state IDLE, `busy` 0, `est_valid` 0, `est_sto` 0, `peak_idx` 0, `peak_met` 0, `err` 0.
- `busy` rises on the edge that samples `start`.
- Latency: the edge accepting the final sample enters CALC. The next edge registers the outputs and raises `est_valid` for exactly one cycle. `busy` falls on that same edge.
- Minimum window-to-window spacing: W+2 cycles with `met_valid` held high and `start` pulsed on the `est_valid` cycle.
- Asynchronous reset mid-SEARCH returns all state and outputs to reset values immediately. No estimate is emitted.

## Configuration
- `STO_AVG_EN` defined:
  - after CALC, the clamped-free signed d is added to an accumulator and a window counter increments;
  - if fewer than 2^AVG_LOG2 windows are done, return to SEARCH automatically, keeping the latched config;
  - on the last window, output `floor(sum / 2^AVG_LOG2)` (arithmetic shift), apply the same clamp and `err` rules, pulse `est_valid` once, and go to IDLE;
  - `peak_idx`/`peak_met` report the final window;
  - `start` or reset clears the accumulator.
- `STO_AVG_EN` undefined: single-window operation as above. No accumulator logic is synthesised.

## Test plan
- Peak position: nfft=64, ng=16, com_delay=3, 80 samples with a single max 900 at i=20 → `est_valid` 2 edges after the last sample, `est_sto` = 57, `peak_idx` = 20, `peak_met` = 900, `err` = 0.
- Tie-break: equal max 500 at i=5 and i=40, same config → `peak_idx` = 5, `est_sto` = 72.
- Underflow: com_delay=70, peak at i=15 → d = -5, so `est_sto` = 0, `err` = 1. Also W=0 on `start` → `est_valid` next-next cycle, `err` = 1.
- Stall and abort: random `met_valid` gaps give the same result as contiguous input. `start` at i=30 restarts, and only one `est_valid` is seen after 80 further samples.
- Reset: `rst_n` low at i=40 → all outputs 0 asynchronously, and no `est_valid` afterwards without a new `start`.
- Averaging (`STO_AVG_EN`, AVG_LOG2=2): peaks at 20, 22, 20, 22 → a single `est_valid`, `est_sto` = 56, `peak_idx` = 22.
